maxpool1d_layer: RTL

Parallel 1-D max-pooling layer sitting directly downstream of the parallel 1-D convolution layer. It consumes the NUM_FILTERS lockstep convolution outputs and reduces each filter's stream by taking the signed maximum over non-overlapping windows of POOL_SIZE samples. It presents one pooled word per filter to the next stage with the same ready/valid handshake.

---
 rtl/cnn1d_pkg.sv | 33 +++
 rtl/maxpool1d_unit.sv | 64 ++++++
 rtl/maxpool1d_layer.sv | 102 ++++++++++
 3 files changed

// File: rtl/cnn1d_pkg.sv
// ---------------------------------------------------------------------------
// cnn1d_pkg : shared constants and helper functions for the 1-D CNN layers
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cnn1d_pkg;

  localparam int POOL_SIZE_DEFAULT = 2;

  // Working width of smax; callers sign-extend their DATA_WIDTH operands to it.
  localparam int SMAX_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Signed maximum; a tie returns a.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool1d_unit.sv
// ---------------------------------------------------------------------------
// maxpool1d_unit : one filter lane of the max-pooling layer (acc + output word)
// Optional macro : MAXPOOL1D_RELU_EN fuses a ReLU into the window start value
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module maxpool1d_unit
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_beat,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0]    r_acc;
  logic [DATA_WIDTH-1:0]    r_data;
  logic signed [SMAX_W-1:0] w_acc_ext;
  logic signed [SMAX_W-1:0] w_data_ext;
  logic                     w_take_data;
  logic [DATA_WIDTH-1:0]    w_max;
  logic [DATA_WIDTH-1:0]    w_init;

  assign w_acc_ext  = SMAX_W'($signed(r_acc));
  assign w_data_ext = SMAX_W'($signed(i_data));

  // Selecting by "smax differs from acc" keeps ties on the accumulator.
  assign w_take_data = (smax(w_acc_ext, w_data_ext) != w_acc_ext);
  assign w_max       = w_take_data ? i_data : r_acc;

`ifdef MAXPOOL1D_RELU_EN
  logic w_data_neg;
  assign w_data_neg = (smax('0, w_data_ext) != w_data_ext);
  assign w_init     = w_data_neg ? '0 : i_data;
`else
  assign w_init     = i_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_data <= '0;
    end else if (i_beat) begin
      if (i_first) begin
        r_acc <= w_init;
      end else if (i_last) begin
        r_data <= w_max;
      end else begin
        r_acc <= w_max;
      end
    end
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/maxpool1d_layer.sv
// ---------------------------------------------------------------------------
// maxpool1d_layer : parallel 1-D max-pooling over NUM_FILTERS lockstep lanes
// Optional macro  : MAXPOOL1D_RELU_EN (fused ReLU, handled in maxpool1d_unit)
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module maxpool1d_layer
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRACTION    = 24,
  parameter int NUM_FILTERS = 32,
  parameter int POOL_SIZE   = POOL_SIZE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   maxpool1d_layer_ready_in,
  input  logic [NUM_FILTERS-1:0] maxpool1d_layer_valid_in,
  input  logic [DATA_WIDTH-1:0]  maxpool1d_layer_data_in  [0:NUM_FILTERS-1],
  input  logic                   maxpool1d_layer_ready_out,
  output logic                   maxpool1d_layer_valid_out,
  output logic [DATA_WIDTH-1:0]  maxpool1d_layer_data_out [0:NUM_FILTERS-1],
  output logic                   maxpool1d_layer_valid_err
);

  localparam int               CNT_W  = clog2(POOL_SIZE);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(POOL_SIZE - 1);

  logic [CNT_W-1:0] r_pool_count;
  logic             r_valid_out;
  logic             r_valid_err;

  logic w_all_valid;
  logic w_any_valid;
  logic w_first;
  logic w_last;
  logic w_ready_in;
  logic w_accept;
  logic w_mismatch;

  // FRACTION does not affect a max; illegal shapes elaborate to nothing extra.
  generate
    if (FRACTION < 0 || FRACTION > DATA_WIDTH || POOL_SIZE < 2) begin : g_cfg_illegal
    end
  endgenerate

  assign w_all_valid = &maxpool1d_layer_valid_in;
  assign w_any_valid = |maxpool1d_layer_valid_in;
  assign w_mismatch  = w_any_valid & ~w_all_valid;
  assign w_first     = (r_pool_count == '0);
  assign w_last      = (r_pool_count == c_last);

  // Only the window-closing beat waits for a stalled output register.
  assign w_ready_in  = ~(w_last & r_valid_out & ~maxpool1d_layer_ready_out);
  assign w_accept    = w_all_valid & w_ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pool_count <= '0;
      r_valid_out  <= 1'b0;
      r_valid_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pool_count <= w_last ? '0 : r_pool_count + CNT_W'(1);
      end

      if (w_accept && w_last) begin
        r_valid_out <= 1'b1;
      end else if (maxpool1d_layer_ready_out) begin
        r_valid_out <= 1'b0;
      end

      if (w_mismatch) begin
        r_valid_err <= 1'b1;
      end
    end
  end

  generate
    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_unit
      maxpool1d_unit #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_unit (
        .clk     (clk),
        .rst     (rst),
        .i_beat  (w_accept),
        .i_first (w_first),
        .i_last  (w_last),
        .i_data  (maxpool1d_layer_data_in[f]),
        .o_data  (maxpool1d_layer_data_out[f])
      );
    end
  endgenerate

  assign maxpool1d_layer_ready_in  = w_ready_in;
  assign maxpool1d_layer_valid_out = r_valid_out;
  assign maxpool1d_layer_valid_err = r_valid_err;

endmodule

`default_nettype wire
